tag_fifo: RTL and testbench

TAG_FIFO -- requirements
Module: tag_fifo

---
 rtl/cobaltmips_pkg.sv | 12 +
 rtl/tag_fifo.sv | 96 +++++++++
 tb/tb_tag_fifo.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/cobaltmips_pkg.sv
// Shared cobaltmips definitions: tag and pointer widths used by the tag
// free-list, the reset sequencer and the reorder buffer.
package cobaltmips_pkg;

    localparam int TAG_W = 6;
    localparam int DEPTH = 2 ** TAG_W;
    localparam int PTR_W = TAG_W + 1;

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [PTR_W-1:0] ptr_t;

endpackage : cobaltmips_pkg

// File: rtl/tag_fifo.sv
// Free-tag list: a circular FIFO of DEPTH tags with wrap-bit pointers.
// Head tag is presented first-word-fall-through for dispatch; tags come
// back on commit. Reset fills the list with every tag, so it starts full.
module tag_fifo
    import cobaltmips_pkg::*;
#(
    parameter int TAG_W = cobaltmips_pkg::TAG_W,
    parameter int DEPTH = cobaltmips_pkg::DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dispatch_ren,
    output logic [TAG_W-1:0] dispatch_tag,
    output logic             dispatch_valid,
    input  logic [TAG_W-1:0] commit_tag,
    input  logic             commit_valid,
    output logic [TAG_W:0]   count,
    output logic             overflow_err,
    output logic             underflow_err
);

    localparam int PTR_W = TAG_W + 1;

    logic [TAG_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] count_r;
    logic             overflow_r;
    logic             underflow_r;

    logic             empty_s;
    logic             full_s;
    logic             pop_s;
    logic             push_s;
    logic             overflow_evt_s;
    logic             underflow_evt_s;
    logic [PTR_W-1:0] rd_ptr_nxt_s;
    logic [PTR_W-1:0] wr_ptr_nxt_s;

    // Occupancy decode, pop/push qualification and next-pointer computation.
    always_comb begin
        empty_s = (rd_ptr_r == wr_ptr_r);
        full_s  = (rd_ptr_r[TAG_W-1:0] == wr_ptr_r[TAG_W-1:0]) &&
                  (rd_ptr_r[TAG_W] != wr_ptr_r[TAG_W]);
        pop_s   = dispatch_ren && !empty_s;
        // When full, a same-cycle pop frees the slot being written. When
        // empty there is no bypass: the pop is refused, the push still lands.
        push_s  = commit_valid && (!full_s || dispatch_ren);
        overflow_evt_s  = commit_valid && full_s && !dispatch_ren;
        underflow_evt_s = dispatch_ren && empty_s;
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
    end

    // State update: reset reloads every tag and overrides any same-cycle traffic.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= TAG_W'(i);
            end
            rd_ptr_r    <= '0;
            wr_ptr_r    <= PTR_W'(DEPTH);
            count_r     <= PTR_W'(DEPTH);
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r[TAG_W-1:0]] <= commit_tag;
            end
            rd_ptr_r <= rd_ptr_nxt_s;
            wr_ptr_r <= wr_ptr_nxt_s;
            count_r  <= wr_ptr_nxt_s - rd_ptr_nxt_s;
            if (overflow_evt_s) begin
                overflow_r <= 1'b1;
            end
            if (underflow_evt_s) begin
                underflow_r <= 1'b1;
            end
        end
    end

    assign dispatch_tag   = mem_r[rd_ptr_r[TAG_W-1:0]];
    assign dispatch_valid = !empty_s;
    assign count          = count_r;
    assign overflow_err   = overflow_r;
    assign underflow_err  = underflow_r;

endmodule : tag_fifo

// File: tb/tb_tag_fifo.sv
// Self-checking bench for tag_fifo. A queue holds the tags the FIFO should
// contain; pops compare dispatch_tag against its front, count against its size.
module tb_tag_fifo;

    localparam int TAG_W = 6;
    localparam int DEPTH = 64;

    logic             clk;
    logic             reset;
    logic             dispatch_ren;
    logic [TAG_W-1:0] dispatch_tag;
    logic             dispatch_valid;
    logic [TAG_W-1:0] commit_tag;
    logic             commit_valid;
    logic [TAG_W:0]   count;
    logic             overflow_err;
    logic             underflow_err;

    logic [TAG_W-1:0] sb [$];
    logic [TAG_W-1:0] exp_tag;
    int               n_checks;
    int               n_fail;

    tag_fifo #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .dispatch_ren   (dispatch_ren),
        .dispatch_tag   (dispatch_tag),
        .dispatch_valid (dispatch_valid),
        .commit_tag     (commit_tag),
        .commit_valid   (commit_valid),
        .count          (count),
        .overflow_err   (overflow_err),
        .underflow_err  (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock with the currently driven inputs; returns at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic refill_model();
        sb.delete();
        for (int i = 0; i < DEPTH; i++) sb.push_back(TAG_W'(i));
    endtask

    task automatic test_reset();
        reset = 1'b0; dispatch_ren = 1'b0; commit_valid = 1'b0; commit_tag = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        refill_model();
        n_checks++; if (count !== 7'd64) begin n_fail++; $display("FAIL reset_count got %0d exp 64", count); end
        n_checks++; if (dispatch_valid !== 1'b1) begin n_fail++; $display("FAIL reset_valid got %b exp 1", dispatch_valid); end
        n_checks++; if (dispatch_tag !== 6'd0) begin n_fail++; $display("FAIL reset_tag got %0d exp 0", dispatch_tag); end
        n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", overflow_err); end
        n_checks++; if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_unf got %b exp 0", underflow_err); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_drain();
        for (int i = 0; i < DEPTH; i++) begin
            exp_tag = sb.pop_front();
            n_checks++;
            if (dispatch_valid !== 1'b1 || dispatch_tag !== exp_tag) begin
                n_fail++;
                $display("FAIL drain_tag[%0d] got %0d/v%b exp %0d/v1", i, dispatch_tag, dispatch_valid, exp_tag);
            end
            dispatch_ren = 1'b1;
            tick();
        end
        dispatch_ren = 1'b0;
        n_checks++; if (dispatch_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid got %b exp 0", dispatch_valid); end
        n_checks++; if (count !== 7'd0) begin n_fail++; $display("FAIL drain_count got %0d exp 0", count); end
    endtask

    task automatic test_push_order();
        logic [TAG_W-1:0] tags [3];
        tags[0] = 6'd5; tags[1] = 6'd9; tags[2] = 6'd63;
        for (int i = 0; i < 3; i++) begin
            commit_valid = 1'b1; commit_tag = tags[i];
            sb.push_back(tags[i]);
            tick();
        end
        commit_valid = 1'b0;
        n_checks++; if (count !== 7'(sb.size())) begin n_fail++; $display("FAIL push_count got %0d exp %0d", count, sb.size()); end
        for (int i = 0; i < 3; i++) begin
            exp_tag = sb.pop_front();
            n_checks++;
            if (dispatch_tag !== exp_tag) begin n_fail++; $display("FAIL push_pop[%0d] got %0d exp %0d", i, dispatch_tag, exp_tag); end
            dispatch_ren = 1'b1;
            tick();
        end
        dispatch_ren = 1'b0;
        n_checks++; if (count !== 7'd0) begin n_fail++; $display("FAIL push_empty_count got %0d exp 0", count); end
    endtask

    task automatic test_underflow();
        dispatch_ren = 1'b1; commit_valid = 1'b1; commit_tag = 6'd12;
        sb.push_back(6'd12);
        tick();
        dispatch_ren = 1'b0; commit_valid = 1'b0;
        n_checks++; if (underflow_err !== 1'b1) begin n_fail++; $display("FAIL unf_flag got %b exp 1", underflow_err); end
        n_checks++; if (count !== 7'd1) begin n_fail++; $display("FAIL unf_count got %0d exp 1", count); end
        n_checks++; if (dispatch_tag !== sb[0]) begin n_fail++; $display("FAIL unf_tag got %0d exp %0d", dispatch_tag, sb[0]); end
        n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL unf_ovf got %b exp 0", overflow_err); end
    endtask

    task automatic test_overflow();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        refill_model();
        n_checks++; if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL ovf_unf_cleared got %b exp 0", underflow_err); end
        commit_valid = 1'b1; commit_tag = 6'd7;
        tick();
        commit_valid = 1'b0;
        n_checks++; if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b exp 1", overflow_err); end
        n_checks++; if (count !== 7'd64) begin n_fail++; $display("FAIL ovf_count got %0d exp 64", count); end
        tick();
        n_checks++; if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", overflow_err); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 2 * DEPTH; i++) begin
            exp_tag = sb.pop_front();
            n_checks++;
            if (dispatch_tag !== exp_tag) begin n_fail++; $display("FAIL wrap_tag[%0d] got %0d exp %0d", i, dispatch_tag, exp_tag); end
            dispatch_ren = 1'b1; commit_valid = 1'b1; commit_tag = 6'd0;
            sb.push_back(6'd0);
            tick();
            n_checks++;
            if (count !== 7'(sb.size())) begin n_fail++; $display("FAIL wrap_count[%0d] got %0d exp %0d", i, count, sb.size()); end
        end
        dispatch_ren = 1'b0; commit_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 10; i++) begin
            exp_tag = sb.pop_front();
            n_checks++;
            if (dispatch_tag !== exp_tag) begin n_fail++; $display("FAIL mid_pop[%0d] got %0d exp %0d", i, dispatch_tag, exp_tag); end
            dispatch_ren = 1'b1;
            tick();
        end
        n_checks++; if (count !== 7'd54) begin n_fail++; $display("FAIL mid_count got %0d exp 54", count); end
        // Reset with traffic on both sides; reset must win.
        reset = 1'b0; dispatch_ren = 1'b1; commit_valid = 1'b1; commit_tag = 6'd33;
        tick();
        reset = 1'b1; dispatch_ren = 1'b0; commit_valid = 1'b0;
        refill_model();
        n_checks++; if (count !== 7'd64) begin n_fail++; $display("FAIL mid_rst_count got %0d exp 64", count); end
        n_checks++; if (dispatch_tag !== 6'd0) begin n_fail++; $display("FAIL mid_rst_tag got %0d exp 0", dispatch_tag); end
        n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ovf got %b exp 0", overflow_err); end
        n_checks++; if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_unf got %b exp 0", underflow_err); end
        n_checks++; if (dispatch_valid !== 1'b1) begin n_fail++; $display("FAIL mid_rst_valid got %b exp 1", dispatch_valid); end
        exp_tag = sb.pop_front();
        dispatch_ren = 1'b1;
        tick();
        dispatch_ren = 1'b0;
        n_checks++; if (dispatch_tag !== sb[0]) begin n_fail++; $display("FAIL mid_after_tag got %0d exp %0d", dispatch_tag, sb[0]); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_drain();
        test_push_order();
        test_underflow();
        test_overflow();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_tag_fifo
